// File: rtl/cdb_arbiter_if.sv
// Completion-bus interface: per-producer result handshake plus the shared
// broadcast outputs of the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_Q  = 5,
  parameter int W_DATA = 40,
  parameter int W_SRC  = $clog2(NUM_Q)
) ();

  logic [NUM_Q-1:0]             req_en;
  logic [NUM_Q-1:0][W_DATA-1:0] req_msg;
  logic [NUM_Q-1:0]             req_ready;
  logic                         cdb_en;
  logic [W_DATA-1:0]            cdb_msg;
  logic [W_SRC-1:0]             cdb_src;

  // Producer side: drives results, watches ready and the broadcast.
  modport master (
    output req_en,
    output req_msg,
    input  req_ready,
    input  cdb_en,
    input  cdb_msg,
    input  cdb_src
  );

  // Arbiter side.
  modport slave (
    input  req_en,
    input  req_msg,
    output req_ready,
    output cdb_en,
    output cdb_msg,
    output cdb_src
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: each producer owns a 2-entry result FIFO; one
// non-empty FIFO per cycle is granted round-robin and its head is
// broadcast through a registered output stage. flash empties every FIFO.
module cdb_arbiter #(
  parameter int NUM_Q  = 5,
  parameter int W_DATA = 40,
  parameter int W_SRC  = $clog2(NUM_Q)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flash,
  cdb_arbiter_if.slave  bus
);

  // Per-producer FIFO storage and bookkeeping.
  logic [W_DATA-1:0] mem_q [NUM_Q][2];
  logic [W_DATA-1:0] mem_d [NUM_Q][2];
  logic [NUM_Q-1:0]  head_q, head_d;
  logic [NUM_Q-1:0]  tail_q, tail_d;
  logic [1:0]        cnt_q [NUM_Q];
  logic [1:0]        cnt_d [NUM_Q];

  // Arbitration state and registered broadcast.
  logic [W_SRC-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_en_q, cdb_en_d;
  logic [W_DATA-1:0] cdb_msg_q, cdb_msg_d;
  logic [W_SRC-1:0]  cdb_src_q, cdb_src_d;

  logic [NUM_Q-1:0]  ready;
  logic [NUM_Q-1:0]  nonempty;
  logic [NUM_Q-1:0]  push;
  logic [NUM_Q-1:0]  pop;
  logic              gnt_vld;
  logic [W_SRC-1:0]  gnt_idx;
  logic [W_SRC:0]    cand_sum;
  logic [W_SRC-1:0]  cand;

  // Ready and occupancy come straight from registered counts; no pop bypass.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      ready[i]    = (cnt_q[i] < 2'd2);
      nonempty[i] = (cnt_q[i] != 2'd0);
      push[i]     = bus.req_en[i] & ready[i] & ~flash;
    end
  end

  // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
  // The extra sum bit lets rr_ptr+k wrap at NUM_Q for non-power-of-2 sizes.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_Q; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (W_SRC+1)'(k);
      if (cand_sum >= (W_SRC+1)'(NUM_Q))
        cand_sum = cand_sum - (W_SRC+1)'(NUM_Q);
      cand = cand_sum[W_SRC-1:0];
      if (!gnt_vld && nonempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Decode the grant into a one-hot pop; no backpressure, so pop is unconditional.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_Q; i++)
      pop[i] = gnt_vld && (gnt_idx == W_SRC'(i));
  end

  // FIFO next state: flash empties everything, else push/pop move pointers.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      if (flash) begin
        head_d[i] = 1'b0;
        tail_d[i] = 1'b0;
        cnt_d[i]  = 2'd0;
      end else begin
        if (push[i]) begin
          mem_d[i][tail_q[i]] = bus.req_msg[i];
          tail_d[i]           = ~tail_q[i];
        end
        if (pop[i])
          head_d[i] = ~head_q[i];
        cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
    end
  end

  // Broadcast stage and rr_ptr update; flash suppresses the grant entirely.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    cdb_en_d  = 1'b0;
    cdb_msg_d = cdb_msg_q;
    cdb_src_d = cdb_src_q;
    if (!flash && gnt_vld) begin
      cdb_en_d  = 1'b1;
      cdb_msg_d = mem_q[gnt_idx][head_q[gnt_idx]];
      cdb_src_d = gnt_idx;
      rr_ptr_d  = (gnt_idx == W_SRC'(NUM_Q-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Control state with synchronous active-low reset (wins over flash/push/pop).
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      for (int unsigned i = 0; i < NUM_Q; i++)
        cnt_q[i] <= '0;
      rr_ptr_q  <= '0;
      cdb_en_q  <= 1'b0;
      cdb_msg_q <= '0;
      cdb_src_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      cdb_en_q  <= cdb_en_d;
      cdb_msg_q <= cdb_msg_d;
      cdb_src_q <= cdb_src_d;
    end
  end

  // Payload storage needs no reset: counts gate every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.req_ready = ready;
  assign bus.cdb_en    = cdb_en_q;
  assign bus.cdb_msg   = cdb_msg_q;
  assign bus.cdb_src   = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_Q, default 5, giving the number of result producers sharing the completion bus.
REQ-002 The block SHALL have parameter W_DATA, default 40, giving the result payload width in bits.
REQ-003 The block SHALL have parameter W_SRC, default $clog2(NUM_Q), giving the width of the source index.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; 0 = reset asserted.
REQ-006 flash  input  1  synchronous pipeline flush on branch mispredict; active-high.
REQ-007 req_en  input  NUM_Q  per-producer result-valid strobe.
REQ-008 req_msg  input  NUM_Q x W_DATA  per-producer result payload.
REQ-009 req_ready  output  NUM_Q  per-producer "can accept" flag.
REQ-010 cdb_en  output  1  completion broadcast valid; exactly one cycle per result.
REQ-011 cdb_msg  output  W_DATA  broadcast payload.
REQ-012 cdb_src  output  W_SRC  index of the producer whose result is being broadcast.

Function
REQ-013 Each producer i SHALL own a 2-entry FIFO, holding head/tail pointers and a 2-bit count.
REQ-014 req_ready[i] SHALL be (count_i < 2), taken from registered state with no same-cycle bypass from a pop.
REQ-015 A push SHALL occur when req_en[i] & req_ready[i] & ~flash.
  - req_en[i] while ~req_ready[i] is a protocol violation; the result is dropped and the FIFO is unchanged.
REQ-016 Each cycle, the arbiter SHALL grant at most one non-empty FIFO, chosen by round-robin starting at index rr_ptr.
REQ-017 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_Q; with no grant, rr_ptr SHALL hold.
REQ-018 The granted FIFO SHALL pop its head into the output register, giving cdb_en=1, cdb_msg=head and cdb_src=g on the next cycle.
REQ-019 With no grant, cdb_en SHALL be 0 on the next cycle, and cdb_msg/cdb_src SHALL hold their previous values.
REQ-020 There is no backpressure on the completion bus; a pop SHALL be unconditional once granted.
REQ-021 Latency: a push accepted at edge t SHALL be able to appear on cdb_en at the earliest in the cycle after edge t+1 (2 cycles from request).
REQ-022 Simultaneous push and pop on the same FIFO SHALL leave its count unchanged and preserve FIFO order.
REQ-023 Fairness: a non-empty FIFO SHALL be granted within NUM_Q consecutive cycles.
REQ-024 Pointers SHALL wrap modulo 2; rr_ptr SHALL wrap from NUM_Q-1 to 0, including when NUM_Q is not a power of 2.
REQ-025 flash=1 at edge t SHALL:
  - empty all FIFOs;
  - drop any same-cycle push;
  - force cdb_en=0 after edge t, suppressing any grant made that cycle;
  - leave rr_ptr unchanged.
REQ-026 Results SHALL never be duplicated or reordered within a producer; ordering across producers is unconstrained.

Reset
REQ-027 reset=0 at a rising edge SHALL clear all FIFO counts and pointers, set rr_ptr=0, cdb_en=0, cdb_msg=0 and cdb_src=0; this gives req_ready=all-ones after the edge.
REQ-028 reset SHALL take priority over flash and over any push or pop in the same cycle.
REQ-029 Mid-operation reset SHALL discard all buffered results, with no cdb_en pulse in the cycle after the reset edge.

Verification
REQ-030 Single push: req_en[2]=1, msg=0x12345 at cycle 0, idle thereafter -> cdb_en=1, cdb_msg=0x12345, cdb_src=2 in cycle 2 only.
REQ-031 All-contend: all 5 producers push one result in the same cycle with rr_ptr=0 -> cdb_src sequence 0,1,2,3,4 on 5 consecutive cycles, then cdb_en=0.
REQ-032 Full FIFO: producer 1 pushes 0xA, then 0xB, while producer 0 holds the grant chain busy -> req_ready[1]=0 while holding 2 entries; outputs 0xA before 0xB; req_ready[1] returns to 1 the cycle after the first pop.
REQ-033 Flash: 3 results buffered; flash=1 in the same cycle as a new push to producer 4 -> cdb_en=0 for all following cycles until new pushes; req_ready=all-ones.
REQ-034 Reset mid-stream: reset=0 while 4 results are buffered and cdb_en=1 -> cdb_en=0, cdb_src=0, rr_ptr=0 after the edge; the next push to producer 3 appears 2 cycles later with cdb_src=3.
REQ-035 Wrap and fairness: producers 4 and 0 push continuously with rr_ptr=4 -> cdb_src alternates 4,0,4,0 with no starvation, and no result is lost or duplicated over 100 cycles.
